muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle sequencer for the HI/LO multiply/divide resource in the EX stage. It accepts the one-hot `mul_control` code produced by the ID decoder together with the rs/rt operands. It runs a pipelined multiply or an iterative radix-2 divide, and owns the architectural HI/LO registers. It stalls the pipeline through `busy`, cancels on exception flush, and services mthi/mtlo writes.

## Interface
Parameters:
- `MUL_LAT`, default 2: multiply latency in cycles after accept; legal range 1..4.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  EX-stage instruction valid carrying a mul/div op.
- `mul_control`  in  4  one-hot op: [0]=mult, [1]=multu, [2]=div, [3]=divu.
- `src_a`  in  32  rs value (multiplicand / dividend).
- `src_b`  in  32  rt value (multiplier / divisor).
- `flush`  in  1  exception/eret flush; cancels any in-flight op.
- `hi_wen`  in  1  mthi write enable.
- `lo_wen`  in  1  mtlo write enable.
- `wdata`  in  32  mthi/mtlo data (rs).
- `busy`  out  1  stall request to IF/ID/EX.
- `done`  out  1  one-cycle pulse; new HI/LO visible this cycle.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States: IDLE, MUL, DIV.
- Accept condition: state==IDLE, `start`=1, `flush`=0, `mul_control`!=0.
- Multi-hot `mul_control` is resolved to its lowest set bit. A `start` with `mul_control`==0 is ignored.
- Operands are latched at accept. A `start` while not IDLE is ignored; upstream holds it under `busy`.
- MUL path:
  - mult uses a signed 32x32 multiply; multu uses unsigned.
  - The 64-bit product is staged through MUL_LAT register stages.
  - HI = product[63:32], LO = product[31:0].
- DIV path, setup at accept:
  - The magnitudes of the operands are latched (signed div) or the raw values (divu).
  - The quotient sign is a[31]^b[31] and the remainder sign is a[31]; both are latched.
- DIV path, iteration:
  - 32 restoring iterations run, one quotient bit per cycle, MSB first.
  - Each iteration uses a 33-bit partial-remainder subtract.
- DIV path, writeback:
  - On the final iteration the signs are applied: LO = quotient, HI = remainder.
  - Signed results follow C truncation. -2^31 / -1 gives LO=0x80000000, HI=0.
- Divide by zero (div or divu):
  - The full 32 iterations still run.
  - The result is forced to LO=0xFFFFFFFF, HI=src_a as latched.
  - No exception is raised.
- `flush`:
  - The state returns to IDLE at the next edge.
  - No HI/LO write and no `done` occur.
  - `flush` beats `start` in the same cycle.
- mthi/mtlo:
  - When `hi_wen`/`lo_wen` is set, HI/LO is written at the edge, in any state.
  - If that edge coincides with op writeback, the mthi/mtlo value wins for that register. The other register takes the op result.
- `busy` = (state!=IDLE) | (accept condition true this cycle). It is combinational so the accept cycle stalls.
- Reset values:
  - `hi`=0, `lo`=0, state IDLE.
  - `done`=0, `busy`=0 (forced 0 while `resetn` low).
  - Iteration counter=0.
- Reset mid-operation aborts with no write.

## Timing
- Accept in cycle 0.
- mult/multu:
  - `busy`=1 in cycles 0..MUL_LAT.
  - HI/LO written at the edge ending cycle MUL_LAT.
  - `done`=1 and `busy`=0 in cycle MUL_LAT+1.
- div/divu:
  - `busy`=1 in cycles 0..32, with iterations in cycles 1..32.
  - HI/LO written at the edge ending cycle 32.
  - `done`=1 and `busy`=0 in cycle 33.
- `done` is registered and lasts exactly one cycle.
- A new accept is allowed in the same cycle `done`=1, giving back-to-back ops with no bubble.
- mfhi/mflo issued in the `done` cycle read the new values. `hi`/`lo` are register outputs with no combinational path from inputs.
- Flush asserted in cycle k of an op gives `busy`=0 in cycle k+1.
- Iteration counter: 6 bits. It is loaded with 0 at accept and the op ends when it reaches 31 (DIV) or MUL_LAT-1 (MUL). There is no wrap beyond these values.

## Test plan
- mult with src_a=0xFFFFFFFD (-3), src_b=5, MUL_LAT=2 -> `busy` high in cycles 0-2; cycle 3 shows `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu with 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then div 0x80000000 / 0xFFFFFFFF accepted in the done cycle -> cycle 33 after that shows lo=0x80000000, hi=0.
- div -7/2 (0xFFFFFFF9, 2) -> `busy` cycles 0-32; cycle 33 shows lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- divu 7/0 and div 0xFFFFFFF0/0 -> lo=0xFFFFFFFF with hi=7 and hi=0xFFFFFFF0 respectively; both complete after 33 cycles.
- Preload hi=0x11. Start div, then assert flush in cycle 10 -> `busy`=0 in cycle 11, no `done`, hi stays 0x11. A start in cycle 11 is accepted.
- Second group, boundary events:
  - Reset mid-op: drive `resetn` low in cycle 5 of a div -> hi=lo=0, `busy`=0 immediately.
  - Writeback collision: assert mtlo with wdata=0xABCD at the edge of a mult writeback -> lo=0xABCD while hi takes the product.
  - Multi-hot: `mul_control`=0b0101 -> executes as mult.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake/data bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The master side drives ops and mthi/mtlo writes; the slave side returns stall, completion and HI/LO.
interface muldiv_if;
    logic        start;
    logic [3:0]  mul_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mul_control, src_a, src_b, flush, hi_wen, lo_wen, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mul_control, src_a, src_b, flush, hi_wen, lo_wen, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: pipelined 32x32 multiply, radix-2 restoring divide,
// architectural HI/LO ownership, pipeline stall, flush cancel and mthi/mtlo service.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic     clk,
    input  logic     resetn,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // ------------------------------------------------------------------
    // Op decode and accept
    // ------------------------------------------------------------------
    logic accept;
    logic is_mul_op;
    logic op_mult;
    logic op_div;
    logic mul_last;
    logic div_last;
    logic finish;

    // Multi-hot codes resolve to the lowest set bit.
    assign op_mult   = bus.mul_control[0];
    assign is_mul_op = bus.mul_control[0] | bus.mul_control[1];
    assign op_div    = bus.mul_control[2] & ~bus.mul_control[1] & ~bus.mul_control[0];

    assign accept = (state_reg == ST_IDLE) & bus.start & ~bus.flush
                  & (bus.mul_control != 4'd0);

    assign mul_last = (state_reg == ST_MUL) && (cnt_reg == MUL_LAST);
    assign div_last = (state_reg == ST_DIV) && (cnt_reg == DIV_LAST);
    assign finish   = (mul_last | div_last) & ~bus.flush;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_mul_op ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL: begin
                if (bus.flush || (cnt_reg == MUL_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (bus.flush || (cnt_reg == DIV_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter holds at its terminal value instead of wrapping when the op leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= 6'd0;
        end else if (accept) begin
            cnt_reg <= 6'd0;
        end else if ((state_reg != ST_IDLE) && (state_next != ST_IDLE)) begin
            cnt_reg <= cnt_reg + 6'd1;
        end
    end

    // ------------------------------------------------------------------
    // Multiply: 64-bit low product of extended operands is the exact
    // signed or unsigned result; the first stage captures it at accept.
    // ------------------------------------------------------------------
    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] mul_product;
    logic [63:0] mul_result;

    assign mul_ext_a   = {{32{op_mult & bus.src_a[31]}}, bus.src_a};
    assign mul_ext_b   = {{32{op_mult & bus.src_b[31]}}, bus.src_b};
    assign mul_product = mul_ext_a * mul_ext_b;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
            logic [63:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (accept && is_mul_op) begin
                        stage_reg <= mul_product;
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    stage_reg <= g_pipe[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign mul_result = g_pipe[MUL_LAT-1].stage_reg;

    // ------------------------------------------------------------------
    // Divide: unsigned restoring core on magnitudes, signs applied at the end
    // ------------------------------------------------------------------
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_reg;
    logic [31:0] rem_reg;
    logic [31:0] divisor_reg;
    logic [31:0] dividend_reg;
    logic        q_neg_reg;
    logic        r_neg_reg;
    logic        div_zero_reg;

    logic [32:0] part_rem;
    logic [32:0] part_diff;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    assign mag_a = (op_div && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign mag_b = (op_div && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    always_ff @(posedge clk) begin
        if (accept && !is_mul_op) begin
            quo_reg      <= mag_a;
            rem_reg      <= 32'd0;
            divisor_reg  <= mag_b;
            dividend_reg <= bus.src_a;
            q_neg_reg    <= op_div & (bus.src_a[31] ^ bus.src_b[31]);
            r_neg_reg    <= op_div & bus.src_a[31];
            div_zero_reg <= (bus.src_b == 32'd0);
        end else if (state_reg == ST_DIV) begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
        end
    end

    // Bit 32 of the difference is the borrow: the remainder is always below the divisor.
    assign part_rem  = {rem_reg, quo_reg[31]};
    assign part_diff = part_rem - {1'b0, divisor_reg};
    assign rem_next  = part_diff[32] ? part_rem[31:0] : part_diff[31:0];
    assign quo_next  = {quo_reg[30:0], ~part_diff[32]};

    assign div_lo = div_zero_reg ? 32'hFFFF_FFFF
                  : (q_neg_reg ? (32'd0 - quo_next) : quo_next);
    assign div_hi = div_zero_reg ? dividend_reg
                  : (r_neg_reg ? (32'd0 - rem_next) : rem_next);

    // ------------------------------------------------------------------
    // Architectural HI/LO: mthi/mtlo beats a same-edge writeback per register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= finish;
            if (bus.hi_wen) begin
                hi_reg <= bus.wdata;
            end else if (finish) begin
                hi_reg <= (state_reg == ST_MUL) ? mul_result[63:32] : div_hi;
            end
            if (bus.lo_wen) begin
                lo_reg <= bus.wdata;
            end else if (finish) begin
                lo_reg <= (state_reg == ST_MUL) ? mul_result[31:0] : div_lo;
            end
        end
    end

    assign bus.busy = resetn & ((state_reg != ST_IDLE) | accept);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: vector table run back-to-back through a scoreboard,
// plus hand-written flush, collision, ignored-start and mid-op reset sequences.
module tb_muldiv_ctrl;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  mc;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of the done cycle.
    task automatic issue(input string name, input logic [3:0] mc, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   cyc;
        bit   busy_ok;
        bus.start       = 1'b1;
        bus.mul_control = mc;
        bus.src_a       = a;
        bus.src_b       = b;
        #1;
        check({name, "/accept_busy"}, 32'(bus.busy), 32'd1);
        e.hi  = ehi;
        e.lo  = elo;
        e.lat = lat;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.mul_control = 4'd0;
        check({name, "/done_low_c1"}, 32'(bus.done), 32'd0);
        cyc     = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        check({name, "/done_cycle"}, 32'(cyc), 32'(e.lat + 1));
        check({name, "/busy_hold"}, 32'(busy_ok), 32'd1);
        check({name, "/busy_at_done"}, 32'(bus.busy), 32'd0);
        check({name, "/hi"}, bus.hi, e.hi);
        check({name, "/lo"}, bus.lo, e.lo);
        $display("op %-12s mc=%b a=%08h b=%08h -> hi=%08h lo=%08h done_cycle=%0d",
                 name, mc, a, b, bus.hi, bus.lo, cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  seen_done;
        vecs[0]  = '{"mult_neg",    4'b0001, 32'hFFFF_FFFD, 32'd5,         LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{"multu_max",   4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{"div_ovf",     4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32,  32'h0000_0000, 32'h8000_0000};
        vecs[3]  = '{"div_m7_2",    4'b0100, 32'hFFFF_FFF9, 32'd2,         32,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{"divu_100_7",  4'b1000, 32'd100,       32'd7,         32,  32'd2,         32'd14};
        vecs[5]  = '{"divu_by0",    4'b1000, 32'd7,         32'd0,         32,  32'd7,         32'hFFFF_FFFF};
        vecs[6]  = '{"div_by0",     4'b0100, 32'hFFFF_FFF0, 32'd0,         32,  32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vecs[7]  = '{"multihot",    4'b0101, 32'hFFFF_FFFD, 32'd5,         LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[8]  = '{"div_7_m2",    4'b0100, 32'd7,         32'hFFFF_FFFE, 32,  32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{"mult_sgn",    4'b0001, 32'h8000_0000, 32'd2,         LAT, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{"multu_uns",   4'b0010, 32'h8000_0000, 32'd2,         LAT, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{"divu_big",    4'b1000, 32'hFFFF_FFF9, 32'd2,         32,  32'd1,         32'h7FFF_FFFC};

        bus.start       = 1'b0;
        bus.mul_control = 4'd0;
        bus.src_a       = 32'd0;
        bus.src_b       = 32'd0;
        bus.flush       = 1'b0;
        bus.hi_wen      = 1'b0;
        bus.lo_wen      = 1'b0;
        bus.wdata       = 32'd0;

        // Reset state, including busy forced low against a valid start.
        repeat (2) @(negedge clk);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/hi", bus.hi, 32'd0);
        check("rst/lo", bus.lo, 32'd0);
        bus.start       = 1'b1;
        bus.mul_control = 4'b0001;
        #1;
        check("rst/busy_vs_start", 32'(bus.busy), 32'd0);
        bus.start       = 1'b0;
        bus.mul_control = 4'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Table, each op accepted in the done cycle of the previous one.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].name, vecs[i].mc, vecs[i].a, vecs[i].b, vecs[i].lat,
                  vecs[i].ehi, vecs[i].elo);
        end

        // start with mul_control==0 is ignored.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.mul_control = 4'd0;
        #1;
        check("zero_mc/busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_mc/busy_next", 32'(bus.busy), 32'd0);
        check("zero_mc/done", 32'(bus.done), 32'd0);

        // Flush mid-divide leaves HI untouched and frees the unit next cycle.
        bus.hi_wen = 1'b1;
        bus.wdata  = 32'h11;
        @(negedge clk);
        bus.hi_wen = 1'b0;
        check("mthi/hi", bus.hi, 32'h11);
        bus.start       = 1'b1;
        bus.mul_control = 4'b0100;
        bus.src_a       = 32'hFFFF_FFF9;
        bus.src_b       = 32'd2;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.mul_control = 4'd0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush/busy_k1", 32'(bus.busy), 32'd0);
        check("flush/done", 32'(bus.done), 32'd0);
        check("flush/hi_kept", bus.hi, 32'h11);
        $display("flush at cycle 10: busy=%0d done=%0d hi=%08h", bus.busy, bus.done, bus.hi);
        issue("post_flush", 4'b1000, 32'd100, 32'd7, 32, 32'd2, 32'd14);

        // mtlo on the multiply writeback edge wins for LO only.
        bus.start       = 1'b1;
        bus.mul_control = 4'b0010;
        bus.src_a       = 32'h0001_0000;
        bus.src_b       = 32'h0003_0000;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.mul_control = 4'd0;
        @(negedge clk);
        bus.lo_wen = 1'b1;
        bus.wdata  = 32'h0000_ABCD;
        @(negedge clk);
        bus.lo_wen = 1'b0;
        check("collide/done", 32'(bus.done), 32'd1);
        check("collide/lo", bus.lo, 32'h0000_ABCD);
        check("collide/hi", bus.hi, 32'h0000_0003);
        $display("collision: hi=%08h lo=%08h done=%0d", bus.hi, bus.lo, bus.done);

        // Reset in cycle 5 of a divide aborts with no write.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.mul_control = 4'b0100;
        bus.src_a       = 32'd100;
        bus.src_b       = 32'd7;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.mul_control = 4'd0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst/busy", 32'(bus.busy), 32'd0);
        check("midrst/hi", bus.hi, 32'd0);
        check("midrst/lo", bus.lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        check("midrst/no_resume", 32'(seen_done), 32'd0);
        check("midrst/hi_after", bus.hi, 32'd0);
        check("midrst/lo_after", bus.lo, 32'd0);
        $display("mid-op reset: hi=%08h lo=%08h activity=%0d", bus.hi, bus.lo, seen_done);
        issue("after_rst", 4'b0010, 32'd2, 32'd3, LAT, 32'd0, 32'd6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
